// File: rtl/seg7_digit_reader.sv
// seg7_digit_reader
//   Receive-side monitor for the seven-segment bus. It synchronizes the segment pattern and
//   waits until the pattern is stable. It then decodes the pattern back to a hex digit, checks
//   that successive digits advance by +1 mod 16, and keeps a saturating count of protocol errors.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_in       segment bus, active-high, bit0=a .. bit6=g, asynchronous to clk
//   clr_err      synchronous clear of err_cnt and of the previous-digit history
//   digit        last accepted digit, holds between accepts
//   digit_valid  1-cycle pulse: a new valid digit was accepted
//   invalid      1-cycle pulse: a stable pattern was not in the decode table
//   seq_err      1-cycle pulse with digit_valid: digit did not follow the previous digit
//   blank        level: the last accepted pattern was all-off
//   err_cnt      saturating count of invalid and seq_err events

module seg7_digit_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    input  logic             clr_err,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             invalid,
    output logic             seq_err,
    output logic             blank,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {StWait, StSettle, StAccept} state_e;

    localparam logic [3:0]       StabMax = 4'(STABLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ErrMax  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ErrOne  = {{(ERR_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [6:0]       seg_meta_q, seg_meta_d;
    logic [6:0]       seg_s_q, seg_s_d;
    logic [3:0]       stab_cnt_q, stab_cnt_d;
    logic [6:0]       last_seg_q, last_seg_d;
    logic [6:0]       cand_q, cand_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic             invalid_q, invalid_d;
    logic             seq_err_q, seq_err_d;
    logic             blank_q, blank_d;
    logic             have_prev_q, have_prev_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic       dec_hit;
    logic [3:0] dec_code;
    logic       err_inc;

    // Decode table, g..a ordering.
    always_comb begin
        dec_hit  = 1'b1;
        dec_code = 4'h0;
        unique case (cand_q)
            7'h3F:   dec_code = 4'h0;
            7'h06:   dec_code = 4'h1;
            7'h5B:   dec_code = 4'h2;
            7'h4F:   dec_code = 4'h3;
            7'h66:   dec_code = 4'h4;
            7'h6D:   dec_code = 4'h5;
            7'h7D:   dec_code = 4'h6;
            7'h07:   dec_code = 4'h7;
            7'h7F:   dec_code = 4'h8;
            7'h6F:   dec_code = 4'h9;
            7'h77:   dec_code = 4'hA;
            7'h7C:   dec_code = 4'hB;
            7'h39:   dec_code = 4'hC;
            7'h5E:   dec_code = 4'hD;
            7'h79:   dec_code = 4'hE;
            7'h71:   dec_code = 4'hF;
            default: dec_hit  = 1'b0;
        endcase
    end

    always_comb begin
        seg_meta_d = seg_in;
        seg_s_d    = seg_meta_q;

        // A count of N means seg_s_q has now matched the previous sample N times in a row.
        if (seg_s_d != seg_s_q) begin
            stab_cnt_d = 4'd0;
        end else if (stab_cnt_q == StabMax) begin
            stab_cnt_d = stab_cnt_q;
        end else begin
            stab_cnt_d = stab_cnt_q + 4'd1;
        end

        state_d       = state_q;
        last_seg_d    = last_seg_q;
        cand_d        = cand_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        invalid_d     = 1'b0;
        seq_err_d     = 1'b0;
        blank_d       = blank_q;
        have_prev_d   = have_prev_q;
        err_inc       = 1'b0;

        unique case (state_q)
            StWait: begin
                if (seg_s_q != last_seg_q) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Falling back to the accepted pattern means the change was a glitch.
                if (seg_s_q == last_seg_q) begin
                    state_d = StWait;
                end else if (stab_cnt_q == StabMax) begin
                    state_d = StAccept;
                    cand_d  = seg_s_q;
                end
            end
            StAccept: begin
                state_d    = StWait;
                last_seg_d = cand_q;
                if (cand_q == 7'h00) begin
                    blank_d     = 1'b1;
                    have_prev_d = 1'b0;
                end else if (dec_hit) begin
                    digit_d       = dec_code;
                    digit_valid_d = 1'b1;
                    blank_d       = 1'b0;
                    if (have_prev_q && (dec_code != (digit_q + 4'd1))) begin
                        seq_err_d = 1'b1;
                        err_inc   = 1'b1;
                    end
                    have_prev_d = 1'b1;
                end else begin
                    invalid_d = 1'b1;
                    err_inc   = 1'b1;
                end
            end
            default: state_d = StWait;
        endcase

        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d   = '0;
            have_prev_d = 1'b0;
        end else if (err_inc && (err_cnt_q != ErrMax)) begin
            err_cnt_d = err_cnt_q + ErrOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StWait;
            seg_meta_q    <= 7'h00;
            seg_s_q       <= 7'h00;
            stab_cnt_q    <= 4'd0;
            last_seg_q    <= 7'h00;
            cand_q        <= 7'h00;
            digit_q       <= 4'h0;
            digit_valid_q <= 1'b0;
            invalid_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            blank_q       <= 1'b1;
            have_prev_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            seg_meta_q    <= seg_meta_d;
            seg_s_q       <= seg_s_d;
            stab_cnt_q    <= stab_cnt_d;
            last_seg_q    <= last_seg_d;
            cand_q        <= cand_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            invalid_q     <= invalid_d;
            seq_err_q     <= seq_err_d;
            blank_q       <= blank_d;
            have_prev_q   <= have_prev_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign invalid     = invalid_q;
    assign seq_err     = seq_err_q;
    assign blank       = blank_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg7_digit_reader.sv
module tb_seg7_digit_reader;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       clr_err;
    logic [3:0] digit;
    logic       digit_valid;
    logic       invalid;
    logic       seq_err;
    logic       blank;
    logic [7:0] err_cnt;

    logic [6:0] seg_in2;
    logic       clr_err2;
    logic [3:0] digit2;
    logic       digit_valid2;
    logic       invalid2;
    logic       seq_err2;
    logic       blank2;
    logic [1:0] err_cnt2;

    int checks = 0;
    int errors = 0;

    // Observations collected by present()
    int         n_valid;
    int         n_inv;
    int         n_seq;
    int         p_idx;
    logic [3:0] p_digit;
    logic       p_seq;

    seg7_digit_reader #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .clr_err(clr_err),
        .digit(digit), .digit_valid(digit_valid), .invalid(invalid),
        .seq_err(seq_err), .blank(blank), .err_cnt(err_cnt)
    );

    seg7_digit_reader #(.STABLE_CYCLES(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in2), .clr_err(clr_err2),
        .digit(digit2), .digit_valid(digit_valid2), .invalid(invalid2),
        .seq_err(seq_err2), .blank(blank2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive pat just after a falling edge and watch the outputs for hold falling edges.
    // Index 1 is the falling edge after the first rising edge that sees pat.
    task automatic present(input logic [6:0] pat, input int hold);
        n_valid = 0; n_inv = 0; n_seq = 0; p_idx = 0; p_digit = 4'h0; p_seq = 1'b0;
        @(negedge clk);
        seg_in = pat;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (digit_valid) begin
                n_valid++;
                p_digit = digit;
                p_seq   = seq_err;
                if (p_idx == 0) p_idx = i;
            end
            if (invalid) begin
                n_inv++;
                if (p_idx == 0) p_idx = i;
            end
            if (seq_err) n_seq++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (digit !== 4'h0 || blank !== 1'b1 || err_cnt !== 8'd0 || digit_valid !== 1'b0 ||
                invalid !== 1'b0 || seq_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc %0d: digit=%h blank=%b err=%0d v/i/s=%b%b%b, need 0 1 0 000",
                         i, digit, blank, err_cnt, digit_valid, invalid, seq_err);
            end
            seg_in = (i % 2 == 0) ? 7'h3F : 7'h00;
        end
        @(negedge clk);
        seg_in = 7'h00;
        rst_n  = 1'b1;
        present(7'h3F, 10);
        checks++;
        if (n_valid !== 1 || p_digit !== 4'h0 || n_seq !== 0 || n_inv !== 0) begin
            errors++;
            $display("FAIL reset_release: valid=%0d digit=%h seq=%0d inv=%0d, need 1 0 0 0",
                     n_valid, p_digit, n_seq, n_inv);
        end
        checks++;
        if (p_idx !== 7) begin
            errors++;
            $display("FAIL reset_latency: pulse at %0d, need 7", p_idx);
        end
    endtask

    task automatic test_sequence();
        logic [6:0] pats [4];
        pats[0] = 7'h3F; pats[1] = 7'h06; pats[2] = 7'h5B; pats[3] = 7'h4F;
        present(7'h00, 10);
        checks++;
        if (blank !== 1'b1 || n_valid !== 0 || n_inv !== 0) begin
            errors++;
            $display("FAIL seq_blank: blank=%b valid=%0d inv=%0d, need 1 0 0", blank, n_valid, n_inv);
        end
        for (int k = 0; k < 4; k++) begin
            present(pats[k], 10);
            checks++;
            if (n_valid !== 1 || p_idx !== 7 || p_digit !== 4'(k) || n_seq !== 0 || n_inv !== 0) begin
                errors++;
                $display("FAIL seq_digit %0d: valid=%0d idx=%0d digit=%h seq=%0d inv=%0d, need 1 7 %0d 0 0",
                         k, n_valid, p_idx, p_digit, n_seq, n_inv, k);
            end
        end
    endtask

    task automatic test_glitch();
        present(7'h00, 10);
        present(7'h06, 10);
        checks++;
        if (n_valid !== 1 || p_digit !== 4'h1 || n_seq !== 0) begin
            errors++;
            $display("FAIL glitch_setup: valid=%0d digit=%h seq=%0d, need 1 1 0", n_valid, p_digit, n_seq);
        end
        present(7'h7F, 2);
        checks++;
        if (n_valid + n_inv !== 0) begin
            errors++;
            $display("FAIL glitch_short: pulses=%0d, need 0", n_valid + n_inv);
        end
        present(7'h06, 10);
        checks++;
        if (n_valid + n_inv + n_seq !== 0 || digit !== 4'h1) begin
            errors++;
            $display("FAIL glitch_return: pulses=%0d digit=%h, need 0 1", n_valid + n_inv + n_seq, digit);
        end
    endtask

    task automatic test_skip_wrap();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (digit !== 4'h1 || blank !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_keeps_digit: digit=%h blank=%b err=%0d, need 1 0 0", digit, blank, err_cnt);
        end
        present(7'h71, 10);
        checks++;
        if (n_valid !== 1 || p_digit !== 4'hF || n_seq !== 0) begin
            errors++;
            $display("FAIL skip_first: valid=%0d digit=%h seq=%0d, need 1 f 0", n_valid, p_digit, n_seq);
        end
        present(7'h3F, 10);
        checks++;
        if (n_valid !== 1 || p_digit !== 4'h0 || n_seq !== 0) begin
            errors++;
            $display("FAIL wrap_f_to_0: valid=%0d digit=%h seq=%0d, need 1 0 0", n_valid, p_digit, n_seq);
        end
        present(7'h5B, 10);
        checks++;
        if (n_valid !== 1 || p_digit !== 4'h2 || n_seq !== 1 || p_seq !== 1'b1) begin
            errors++;
            $display("FAIL skip_0_to_2: valid=%0d digit=%h seq=%0d coincident=%b, need 1 2 1 1",
                     n_valid, p_digit, n_seq, p_seq);
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL skip_errcnt: err_cnt=%0d, need 1", err_cnt);
        end
    endtask

    task automatic test_invalid();
        present(7'h01, 8);
        checks++;
        if (n_inv !== 1 || n_valid !== 0 || p_idx !== 7 || digit !== 4'h2 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL invalid_pat: inv=%0d valid=%0d idx=%0d digit=%h err=%0d, need 1 0 7 2 2",
                     n_inv, n_valid, p_idx, digit, err_cnt);
        end
        present(7'h00, 10);
        checks++;
        if (blank !== 1'b1 || n_valid + n_inv + n_seq !== 0) begin
            errors++;
            $display("FAIL invalid_blank: blank=%b pulses=%0d, need 1 0", blank, n_valid + n_inv + n_seq);
        end
        present(7'h4F, 10);
        checks++;
        if (n_valid !== 1 || p_digit !== 4'h3 || n_seq !== 0 || blank !== 1'b0) begin
            errors++;
            $display("FAIL after_blank: valid=%0d digit=%h seq=%0d blank=%b, need 1 3 0 0",
                     n_valid, p_digit, n_seq, blank);
        end
        present(7'h00, 10);
        present(7'h7F, 10);
        checks++;
        if (n_valid !== 1 || p_digit !== 4'h8 || n_seq !== 0 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL blank_clears_prev: valid=%0d digit=%h seq=%0d err=%0d, need 1 8 0 2",
                     n_valid, p_digit, n_seq, err_cnt);
        end
    endtask

    task automatic test_saturation();
        int         n2;
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        for (int e = 0; e < 5; e++) begin
            n2 = 0;
            @(negedge clk);
            seg_in2 = (e % 2 == 1) ? 7'h02 : 7'h01;
            repeat (8) begin
                @(negedge clk);
                if (invalid2) n2++;
            end
            checks++;
            if (n2 !== 1 || err_cnt2 !== exp_cnt[e]) begin
                errors++;
                $display("FAIL sat_event %0d: inv=%0d err_cnt=%0d, need 1 %0d", e, n2, err_cnt2, exp_cnt[e]);
            end
        end
        @(negedge clk);
        seg_in2 = 7'h02;
        repeat (6) @(negedge clk);
        clr_err2 = 1'b1;
        @(negedge clk);
        clr_err2 = 1'b0;
        checks++;
        if (invalid2 !== 1'b1 || err_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL clr_priority: invalid=%b err_cnt=%0d, need 1 0", invalid2, err_cnt2);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL clr_hold: err_cnt=%0d, need 0", err_cnt2);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        seg_in   = 7'h00;
        clr_err  = 1'b0;
        seg_in2  = 7'h00;
        clr_err2 = 1'b0;
        test_reset();
        test_sequence();
        test_glitch();
        test_skip_wrap();
        test_invalid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
